pc_fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of the single-cycle control decoder. Holds the PC and fetches each instruction from instruction memory over a req/ack handshake, then presents the instruction and its decoded fields (op, funct, rs, rt, rd, imm16) for one execute window. At the end of that window it samples the decoder's pcsrc/jump outputs and forms the next PC. Also maintains a retired-instruction counter and a halt state.

---
 rtl/pc_fetch_unit.sv | 201 ++++++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : Instruction-fetch stage placed ahead of the single-cycle
//               control decoder. It holds the PC and fetches each instruction
//               over a req/ack handshake. The instruction and its decoded
//               fields are then presented for one execute window. At the end
//               of that window the decoder's pcsrc/jump outputs are sampled
//               to form the next PC. The block also keeps a retired-
//               instruction counter and a terminal halt state.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   1          system clock, rising edge
//   reset       in   1          asynchronous active-high reset
//   stall       in   1          hold current instruction in EXEC
//   pcsrc       in   1          branch taken (from control decoder)
//   jump        in   1          jump (from control decoder)
//   imem_req    out  1          fetch request (registered)
//   imem_addr   out  32         fetch byte address (= pc)
//   imem_ack    in   1          imem_rdata valid this cycle
//   imem_rdata  in   32         instruction word from memory
//   instr       out  32         instruction register
//   op          out  6          instr[31:26]
//   funct       out  6          instr[5:0]
//   rs          out  5          instr[25:21]
//   rt          out  5          instr[20:16]
//   rd          out  5          instr[15:11]
//   imm16       out  16         instr[15:0]
//   instr_valid out  1          high while in EXEC
//   pc          out  32         address of current instruction
//   pc_plus4    out  32         pc + 4 (modulo 2^32)
//   halted      out  1          HALT state reached
//   retired     out  CNT_WIDTH  instructions that have left EXEC
// ============================================================================
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [5:0]  HALT_OP   = 6'b111111,
   parameter int          CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 stall,
   input  logic                 pcsrc,
   input  logic                 jump,
   output logic                 imem_req,
   output logic [31:0]          imem_addr,
   input  logic                 imem_ack,
   input  logic [31:0]          imem_rdata,
   output logic [31:0]          instr,
   output logic [5:0]           op,
   output logic [5:0]           funct,
   output logic [4:0]           rs,
   output logic [4:0]           rt,
   output logic [4:0]           rd,
   output logic [15:0]          imm16,
   output logic                 instr_valid,
   output logic [31:0]          pc,
   output logic [31:0]          pc_plus4,
   output logic                 halted,
   output logic [CNT_WIDTH-1:0] retired
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_EXEC = 2'd2,
      S_HALT = 2'd3
   } stateT;

   localparam logic [CNT_WIDTH-1:0] C_RETIRED_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   // Registered state
   stateT                r_state;
   logic [31:0]          r_pc;
   logic [31:0]          r_instr;
   logic                 r_imemReq;
   logic                 r_halted;
   logic [CNT_WIDTH-1:0] r_retired;

   // Next-state values
   stateT                w_stateNext;
   logic [31:0]          w_pcNext;
   logic [31:0]          w_instrNext;
   logic                 w_imemReqNext;
   logic                 w_haltedNext;
   logic [CNT_WIDTH-1:0] w_retiredNext;

   // Next-PC candidates
   logic [31:0]          w_pcPlus4;
   logic [31:0]          w_branchTarget;
   logic [31:0]          w_jumpTarget;
   logic [31:0]          w_targetPc;

   assign w_pcPlus4      = r_pc + 32'd4;
   // Sign-extend imm16 to 30 bits, then shift left by two to get a word offset.
   assign w_branchTarget = w_pcPlus4 + {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
   assign w_jumpTarget   = {w_pcPlus4[31:28], r_instr[25:0], 2'b00};

   // jump has priority over pcsrc when the decoder raises both.
   always_comb begin
      w_targetPc = w_pcPlus4;
      if (jump) begin
         w_targetPc = w_jumpTarget;
      end else if (pcsrc) begin
         w_targetPc = w_branchTarget;
      end
   end

   // ------------------------------------------------------------------------
   // State register and datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_pc      <= RESET_PC;
         r_instr   <= 32'h0000_0000;
         r_imemReq <= 1'b0;
         r_halted  <= 1'b0;
         r_retired <= '0;
      end else begin
         r_state   <= w_stateNext;
         r_pc      <= w_pcNext;
         r_instr   <= w_instrNext;
         r_imemReq <= w_imemReqNext;
         r_halted  <= w_haltedNext;
         r_retired <= w_retiredNext;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic. Every register holds its value unless a state says
   // otherwise, so imem_ack outside REQ and pcsrc/jump outside an unstalled
   // EXEC have no effect.
   // ------------------------------------------------------------------------
   always_comb begin
      w_stateNext   = r_state;
      w_pcNext      = r_pc;
      w_instrNext   = r_instr;
      w_imemReqNext = r_imemReq;
      w_haltedNext  = r_halted;
      w_retiredNext = r_retired;

      unique case (r_state)
         S_IDLE: begin
            w_stateNext   = S_REQ;
            w_imemReqNext = 1'b1;
         end

         S_REQ: begin
            if (imem_ack) begin
               w_instrNext   = imem_rdata;
               w_imemReqNext = 1'b0;
               w_stateNext   = S_EXEC;
            end
         end

         S_EXEC: begin
            if (!stall) begin
               if (r_instr[31:26] == HALT_OP) begin
                  w_stateNext  = S_HALT;
                  w_haltedNext = 1'b1;
               end else begin
                  w_retiredNext = r_retired + C_RETIRED_ONE;
                  w_pcNext      = w_targetPc;
                  w_imemReqNext = 1'b1;
                  w_stateNext   = S_REQ;
               end
            end
         end

         S_HALT: begin
            w_imemReqNext = 1'b0;
         end

         default: begin
            w_stateNext = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign imem_req    = r_imemReq;
   assign imem_addr   = r_pc;
   assign instr       = r_instr;
   assign op          = r_instr[31:26];
   assign rs          = r_instr[25:21];
   assign rt          = r_instr[20:16];
   assign rd          = r_instr[15:11];
   assign funct       = r_instr[5:0];
   assign imm16       = r_instr[15:0];
   assign instr_valid = (r_state == S_EXEC);
   assign pc          = r_pc;
   assign pc_plus4    = w_pcPlus4;
   assign halted      = r_halted;
   assign retired     = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Directed self-checking bench for pc_fetch_unit. It covers the
//               wait-state fetch, branch/jump next-PC forms, stall, halt,
//               reset during a fetch and PC wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

   localparam int CNT_WIDTH = 32;

   logic                 clk;
   logic                 reset;
   logic                 stall;
   logic                 pcsrc;
   logic                 jump;
   logic                 imem_req;
   logic [31:0]          imem_addr;
   logic                 imem_ack;
   logic [31:0]          imem_rdata;
   logic [31:0]          instr;
   logic [5:0]           op;
   logic [5:0]           funct;
   logic [4:0]           rs;
   logic [4:0]           rt;
   logic [4:0]           rd;
   logic [15:0]          imm16;
   logic                 instr_valid;
   logic [31:0]          pc;
   logic [31:0]          pc_plus4;
   logic                 halted;
   logic [CNT_WIDTH-1:0] retired;

   int nChecks;
   int nFails;

   pc_fetch_unit #(
      .RESET_PC  (32'h0000_0000),
      .HALT_OP   (6'b111111),
      .CNT_WIDTH (CNT_WIDTH)
   ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .pcsrc       (pcsrc),
      .jump        (jump),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .op          (op),
      .funct       (funct),
      .rs          (rs),
      .rt          (rt),
      .rd          (rd),
      .imm16       (imm16),
      .instr_valid (instr_valid),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .halted      (halted),
      .retired     (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; inputs change and outputs are sampled on the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Wait (bounded) for a request, then answer it with zero wait states.
   task automatic serve(input logic [31:0] word);
      int waited;
      waited = 0;
      while (!imem_req && waited < 20) begin
         tick();
         waited++;
      end
      if (!imem_req) checkEq("reqTimeout", 64'(imem_req), 64'd1);
      imem_ack   = 1'b1;
      imem_rdata = word;
      tick();
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
   endtask

   // Retire the instruction in EXEC with the given decoder outputs.
   task automatic retire(input logic j, input logic b);
      jump  = j;
      pcsrc = b;
      tick();
      jump  = 1'b0;
      pcsrc = 1'b0;
   endtask

   initial begin
      nChecks    = 0;
      nFails     = 0;
      reset      = 1'b1;
      stall      = 1'b0;
      pcsrc      = 1'b0;
      jump       = 1'b0;
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;

      // ---------------- reset state ----------------
      repeat (2) @(negedge clk);
      checkEq("rstPc",      64'(pc),          64'h0);
      checkEq("rstInstr",   64'(instr),       64'h0);
      checkEq("rstReq",     64'(imem_req),    64'd0);
      checkEq("rstValid",   64'(instr_valid), 64'd0);
      checkEq("rstHalted",  64'(halted),      64'd0);
      checkEq("rstRetired", 64'(retired),     64'd0);
      reset = 1'b0;

      // ---------------- fetch with 3 wait cycles ----------------
      for (int i = 0; i < 4; i++) begin
         tick();
         checkEq("waitReq",   64'(imem_req),    64'd1);
         checkEq("waitAddr",  64'(imem_addr),   64'h0);
         checkEq("waitValid", 64'(instr_valid), 64'd0);
      end
      imem_ack   = 1'b1;           // ack in the 4th request cycle
      imem_rdata = 32'h2008_0005;
      tick();
      imem_ack   = 1'b0;
      checkEq("addiValid", 64'(instr_valid), 64'd1);
      checkEq("addiReq",   64'(imem_req),    64'd0);
      checkEq("addiOp",    64'(op),          64'h08);
      checkEq("addiRt",    64'(rt),          64'd8);
      checkEq("addiImm",   64'(imm16),       64'd5);
      checkEq("addiPc4",   64'(pc_plus4),    64'd4);
      retire(1'b0, 1'b0);
      checkEq("addiNextPc", 64'(pc),      64'd4);
      checkEq("addiRet",    64'(retired), 64'd1);
      checkEq("addiReqAgain", 64'(imem_req), 64'd1);

      // ---------------- jump to 0x100, branch back by 8 ----------------
      serve(32'h0800_0040);
      retire(1'b1, 1'b0);
      checkEq("jmp100", 64'(imem_addr), 64'h100);
      serve(32'h1000_FFFE);
      retire(1'b0, 1'b1);
      checkEq("brTaken", 64'(imem_addr), 64'h0FC);
      serve(32'h0800_0040);
      retire(1'b1, 1'b0);
      serve(32'h1000_FFFE);
      retire(1'b0, 1'b0);
      checkEq("brNotTaken", 64'(imem_addr), 64'h104);
      checkEq("ret5",       64'(retired),   64'd5);

      // ---------------- jump + pcsrc together: jump wins ----------------
      serve(32'h0810_0004);
      retire(1'b1, 1'b0);
      checkEq("jmp400010", 64'(imem_addr), 64'h0040_0010);
      serve(32'h0810_0000);
      retire(1'b1, 1'b1);
      checkEq("jmpWins", 64'(imem_addr), 64'h0040_0000);

      // ---------------- stall in EXEC; decoder outputs ignored while stalled --
      serve(32'h012A_4020);
      checkEq("rrRs",    64'(rs),    64'd9);
      checkEq("rrRt",    64'(rt),    64'd10);
      checkEq("rrRd",    64'(rd),    64'd8);
      checkEq("rrFunct", 64'(funct), 64'h20);
      stall = 1'b1;
      pcsrc = 1'b1;
      jump  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checkEq("stallValid", 64'(instr_valid), 64'd1);
         checkEq("stallReq",   64'(imem_req),    64'd0);
      end
      checkEq("stallPc",    64'(pc),      64'h0040_0000);
      checkEq("stallInstr", 64'(instr),   64'h012A_4020);
      checkEq("stallRet",   64'(retired), 64'd7);
      stall = 1'b0;
      retire(1'b0, 1'b0);
      checkEq("unstallPc",  64'(pc),       64'h0040_0004);
      checkEq("unstallRet", 64'(retired),  64'd8);
      checkEq("unstallReq", 64'(imem_req), 64'd1);

      // ---------------- halt ----------------
      serve(32'hFC00_0000);
      retire(1'b1, 1'b1);
      checkEq("haltFlag",  64'(halted),      64'd1);
      checkEq("haltValid", 64'(instr_valid), 64'd0);
      checkEq("haltPc",    64'(pc),          64'h0040_0004);
      checkEq("haltRet",   64'(retired),     64'd8);
      imem_ack   = 1'b1;
      imem_rdata = 32'h1234_5678;
      for (int i = 0; i < 4; i++) begin
         tick();
         checkEq("haltReq", 64'(imem_req), 64'd0);
      end
      imem_ack = 1'b0;
      checkEq("haltInstr", 64'(instr),   64'hFC00_0000);
      checkEq("haltRet2",  64'(retired), 64'd8);
      checkEq("haltFlag2", 64'(halted),  64'd1);

      // ---------------- reset out of HALT, then reset during REQ ----------
      reset = 1'b1;
      #1;
      checkEq("rstHaltClr", 64'(halted),  64'd0);
      checkEq("rstRetClr",  64'(retired), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      tick();
      checkEq("reqAgain", 64'(imem_req), 64'd1);
      serve(32'h2008_0005);
      retire(1'b0, 1'b0);   // now in REQ at pc=4
      imem_ack   = 1'b1;
      imem_rdata = 32'hAAAA_5555;
      reset      = 1'b1;
      #1;
      checkEq("asyncPc",    64'(pc),       64'h0);
      checkEq("asyncInstr", 64'(instr),    64'h0);
      checkEq("asyncReq",   64'(imem_req), 64'd0);
      @(negedge clk);       // a rising edge passes with ack high under reset
      checkEq("rstAckInstr", 64'(instr), 64'h0);
      reset    = 1'b0;
      imem_ack = 1'b0;
      tick();
      checkEq("restartReq",  64'(imem_req),  64'd1);
      checkEq("restartAddr", 64'(imem_addr), 64'h0);

      // ---------------- PC wrap: branch from 0 back to 0xFFFFFFFC ---------
      serve(32'h1000_FFFE);
      retire(1'b0, 1'b1);
      checkEq("wrapAddr", 64'(imem_addr), 64'hFFFF_FFFC);
      checkEq("wrapPc4",  64'(pc_plus4),  64'h0);
      serve(32'h0000_0000);
      retire(1'b0, 1'b0);
      checkEq("wrapNext", 64'(pc),      64'h0);
      checkEq("wrapRet",  64'(retired), 64'd2);

      $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
      $finish;
   end

   // Absolute time limit so the bench ends even if a wait never resolves.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
